mac_dot_sequencer: RTL and testbench

- Upstream control stage for the fp_mac datapath: accepts a stream of fp16 operand pairs and issues them to fp_mac one term at a time.
- Feeds each completed fp32 partial sum back as the MAC's C input, so the chained MAC computes a dot product of programmable length.
- Presents the final fp32 sum on a valid/ready output.
- Throughput is feedback-limited: one term per MAC_LATENCY+1 cycles.

---
 rtl/mac_pkg.sv | 22 ++
 rtl/mac_issue_timer.sv | 32 +++
 rtl/mac_dot_sequencer.sv | 127 ++++++++++++
 tb/tb_mac_dot_sequencer.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared types and constants for the fp_mac dot-product sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mac_pkg;

    localparam int FP16_W = 16;
    localparam int FP32_W = 32;
    localparam logic [FP32_W-1:0] FP32_ZERO = 32'h00000000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

    // Counter width able to hold the value MAC_LATENCY itself
    function automatic int timer_width(input int latency);
        return $clog2(latency + 1);
    endfunction

endpackage

// File: rtl/mac_issue_timer.sv
// Loadable down-counter that flags the final cycle before it reaches zero.
// Latency: expire is high in the cycle whose closing edge takes the count to 0.
// Backpressure: none; load always wins over counting.
module mac_issue_timer #(
    parameter int WIDTH = 3
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             expire
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] count;

    // Load on issue, then count down and park at zero
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - ONE;
        end
    end

    // Combinational so the sequencer acts on the very edge the count hits zero
    assign expire = (count == ONE);

endmodule

// File: rtl/mac_dot_sequencer.sv
// Sequences fp16 operand pairs into fp_mac, feeding each fp32 partial sum back as C.
// Latency: len*(MAC_LATENCY+1) cycles plus input stalls, plus 1 cycle in DONE.
// Backpressure: in_ready only in ISSUE; result held on out_valid until out_ready.
module mac_dot_sequencer
    import mac_pkg::*;
#(
    parameter int MAC_LATENCY = 4,
    parameter int LEN_W       = 8
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic [FP32_W-1:0] init_c,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [FP16_W-1:0] in_a,
    input  logic [FP16_W-1:0] in_b,
    output logic [FP16_W-1:0] mac_a,
    output logic [FP16_W-1:0] mac_b,
    output logic [FP32_W-1:0] mac_c,
    input  logic [FP32_W-1:0] mac_y,
    output logic              busy,
    output logic              out_valid,
    output logic [FP32_W-1:0] out_data,
    input  logic              out_ready
);

    localparam int TMR_W = timer_width(MAC_LATENCY);

    seq_state_t        state;
    logic [FP32_W-1:0] acc;
    logic [LEN_W-1:0]  cnt;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  cnt_inc;
    logic              issue_fire;
    logic              term_done;

    // A term is issued on the accepted handshake; in_ready is only ever high in ISSUE
    assign issue_fire = (state == ISSUE) && in_valid && in_ready;
    assign cnt_inc    = cnt + LEN_W'(1);

    mac_issue_timer #(
        .WIDTH (TMR_W)
    ) u_timer (
        .clock    (clock),
        .resetn   (resetn),
        .load     (issue_fire),
        .load_val (TMR_W'(MAC_LATENCY)),
        .expire   (term_done)
    );

    // Control FSM with all outputs registered alongside the state
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            acc       <= FP32_ZERO;
            cnt       <= '0;
            len_q     <= '0;
            in_ready  <= 1'b0;
            mac_a     <= '0;
            mac_b     <= '0;
            mac_c     <= FP32_ZERO;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= FP32_ZERO;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc  <= init_c;
                        cnt  <= '0;
                        busy <= 1'b1;
                        if (len != '0) begin
                            len_q    <= len;
                            in_ready <= 1'b1;
                            state    <= ISSUE;
                        end else begin
                            // Empty vector: the bias is the answer
                            out_valid <= 1'b1;
                            out_data  <= init_c;
                            state     <= DONE;
                        end
                    end
                end
                ISSUE: begin
                    if (issue_fire) begin
                        mac_a    <= in_a;
                        mac_b    <= in_b;
                        mac_c    <= acc;
                        in_ready <= 1'b0;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    // mac_c stays put so C is stable for the whole MAC pipeline
                    if (term_done) begin
                        acc   <= mac_y;
                        mac_c <= mac_y;
                        cnt   <= cnt_inc;
                        mac_a <= '0;
                        mac_b <= '0;
                        if (cnt_inc == len_q) begin
                            out_valid <= 1'b1;
                            out_data  <= mac_y;
                            state     <= DONE;
                        end else begin
                            in_ready <= 1'b1;
                            state    <= ISSUE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_dot_sequencer.sv
// Bench for mac_dot_sequencer with a behavioural fp_mac (latency 4) attached.
// Directed cases from the block description plus randomized dot products.
// Results are checked against a scoreboard queue filled when stimulus is issued.
module tb_mac_dot_sequencer;

    localparam int L     = 4;
    localparam int LEN_W = 8;

    logic              clock = 1'b0;
    logic              resetn = 1'b0;
    logic              start = 1'b0;
    logic [LEN_W-1:0]  len = '0;
    logic [31:0]       init_c = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [15:0]       in_a = '0;
    logic [15:0]       in_b = '0;
    logic [15:0]       mac_a;
    logic [15:0]       mac_b;
    logic [31:0]       mac_c;
    logic [31:0]       mac_y;
    logic              busy;
    logic              out_valid;
    logic [31:0]       out_data;
    logic              out_ready = 1'b0;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    logic [31:0] exp_q[$];

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    mac_dot_sequencer #(.MAC_LATENCY(L), .LEN_W(LEN_W)) dut (
        .clock     (clock),
        .resetn    (resetn),
        .start     (start),
        .len       (len),
        .init_c    (init_c),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .mac_a     (mac_a),
        .mac_b     (mac_b),
        .mac_c     (mac_c),
        .mac_y     (mac_y),
        .busy      (busy),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
    );

    // ---------------- behavioural fp arithmetic ----------------
    function automatic real h2r(input logic [15:0] h);
        int  e;
        int  m;
        real v;
        e = int'(h[14:10]);
        m = int'(h[9:0]);
        if (e == 0) v = real'(m) * 2.0 ** (-24);
        else        v = (1024.0 + real'(m)) * 2.0 ** (e - 25);
        return h[15] ? -v : v;
    endfunction

    function automatic real f2r(input logic [31:0] f);
        int  e;
        int  m;
        real v;
        e = int'(f[30:23]);
        m = int'(f[22:0]);
        if (e == 0) v = real'(m) * 2.0 ** (-149);
        else        v = (8388608.0 + real'(m)) * 2.0 ** (e - 150);
        return f[31] ? -v : v;
    endfunction

    // Truncating real -> fp32, tiny results flush to signed zero
    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        int          ue;
        logic [7:0]  e8;
        if (r == 0.0) return 32'h0;
        d  = $realtobits(r);
        ue = int'(d[62:52]) - 896;
        if (ue >= 255) return {d[63], 8'hFF, 23'h0};
        if (ue <= 0)   return {d[63], 31'h0};
        e8 = ue[7:0];
        return {d[63], e8, d[51:29]};
    endfunction

    function automatic logic [31:0] fmac(input logic [15:0] a, input logic [15:0] b,
                                         input logic [31:0] c);
        if (a[14:10] == 5'h1F && a[9:0] != 0) return {1'b0, 8'hFF, 1'b1, a[8:0], 13'h0};
        if (b[14:10] == 5'h1F && b[9:0] != 0) return {1'b0, 8'hFF, 1'b1, b[8:0], 13'h0};
        if (c[30:23] == 8'hFF) return c;
        if (a[14:10] == 5'h1F || b[14:10] == 5'h1F) return {a[15] ^ b[15], 8'hFF, 23'h0};
        return r2f(h2r(a) * h2r(b) + f2r(c));
    endfunction

    // fp_mac model: inputs taken at the edge after issue, result valid for edge issue+L
    logic [31:0] mac_pipe [0:L-2];
    always @(posedge clock) begin
        mac_pipe[0] <= fmac(mac_a, mac_b, mac_c);
        for (int i = 1; i < L - 1; i++) mac_pipe[i] <= mac_pipe[i-1];
    end
    assign mac_y = mac_pipe[L-2];

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ctrl"}, {61'h0, in_ready, busy, out_valid}, 64'h0);
        check({tag, "_mac_ab"}, {32'h0, mac_a, mac_b}, 64'h0);
        check({tag, "_mac_c"}, {32'h0, mac_c}, 64'h0);
        check({tag, "_out_data"}, {32'h0, out_data}, 64'h0);
    endtask

    // Result monitor: every accepted output is popped against the scoreboard
    always @(negedge clock) begin
        logic [31:0] e;
        if (resetn && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_result: got %h with empty scoreboard", out_data);
            end else begin
                e = exp_q.pop_front();
                check("out_data", {32'h0, out_data}, {32'h0, e});
            end
        end
    end

    // ---------------- drivers (entered and left at posedge+1) ----------------
    task automatic do_start(input logic [LEN_W-1:0] n, input logic [31:0] c);
        start  = 1'b1;
        len    = n;
        init_c = c;
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    task automatic send_pair(input logic [15:0] a, input logic [15:0] b, output int acc_cyc);
        logic ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clock);
            ok = in_ready;
        end
        if (!ok) check("in_ready_timeout", {63'h0, in_ready}, 64'h1);
        acc_cyc = cyc + 1;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        in_a     = '0;
        in_b     = '0;
    endtask

    task automatic wait_out(input int hold, input logic poke_start);
        logic        ok;
        logic [31:0] d0;
        ok        = 1'b0;
        out_ready = 1'b0;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clock);
            ok = out_valid;
        end
        if (!ok) check("out_valid_timeout", {63'h0, out_valid}, 64'h1);
        d0 = out_data;
        for (int i = 0; i < hold; i++) begin
            @(negedge clock);
            check("hold_valid_rdy", {62'h0, out_valid, in_ready}, 64'h2);
            check("hold_data", {32'h0, out_data}, {32'h0, d0});
            if (poke_start) begin
                start = 1'b1;
                len   = 8'd3;
            end
        end
        @(posedge clock);
        #1;
        start     = 1'b0;
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        out_ready = 1'b0;
        check("release", {62'h0, busy, out_valid}, 64'h0);
    endtask

    task automatic run_dot(input int n, input logic [31:0] c, input int max_gap,
                           input int hold);
        logic [15:0] a[$];
        logic [15:0] b[$];
        logic [31:0] expv;
        int          t;
        expv = c;
        for (int i = 0; i < n; i++) begin
            logic [15:0] va;
            logic [15:0] vb;
            va = {1'($urandom), 5'($urandom_range(10, 20)), 10'($urandom)};
            vb = {1'($urandom), 5'($urandom_range(10, 20)), 10'($urandom)};
            if ($urandom_range(0, 11) == 0) va = {6'b0_11111, 1'b1, 9'($urandom)};
            a.push_back(va);
            b.push_back(vb);
            expv = fmac(va, vb, expv);
        end
        exp_q.push_back(expv);
        do_start(LEN_W'(n), c);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, max_gap)) begin
                @(posedge clock);
                #1;
            end
            send_pair(a[i], b[i], t);
        end
        wait_out(hold, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int t1;
        int t;

        // Reset state
        repeat (2) @(negedge clock);
        check_zero("reset");
        resetn = 1'b1;
        @(posedge clock);
        #1;

        // Basic: 1*2 + 2*3 = 8.0, second term accepted L+1 cycles after the first
        exp_q.push_back(32'h41000000);
        do_start(8'd2, 32'h00000000);
        send_pair(16'h3C00, 16'h4000, t0);
        send_pair(16'h4000, 16'h4200, t1);
        check("term_spacing", 64'(t1 - t0), 64'(L + 1));
        wait_out(0, 1'b0);

        // Bias: first issue carries init_c on mac_c
        exp_q.push_back(32'h41100000);
        do_start(8'd2, 32'h3F800000);
        send_pair(16'h3C00, 16'h4000, t);
        check("bias_mac_c", {32'h0, mac_c}, {32'h0, 32'h3F800000});
        check("bias_mac_ab", {32'h0, mac_a, mac_b}, {32'h0, 32'h3C004000});
        send_pair(16'h4000, 16'h4200, t);
        wait_out(0, 1'b0);

        // Zero length: straight to DONE with the bias, nothing issued
        exp_q.push_back(32'h40400000);
        do_start(8'd0, 32'h40400000);
        check("zero_len_valid_rdy", {62'h0, out_valid, in_ready}, 64'h2);
        check("zero_len_data", {32'h0, out_data}, {32'h0, 32'h40400000});
        check("zero_len_mac_a", {48'h0, mac_a}, 64'h0);
        wait_out(0, 1'b0);

        // Input stall in ISSUE, then output back-pressure with start poked
        exp_q.push_back(32'h40000000);
        do_start(8'd1, 32'h00000000);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("stall_rdy_busy", {62'h0, in_ready, busy}, 64'h3);
            check("stall_mac_a", {48'h0, mac_a}, 64'h0);
        end
        @(posedge clock);
        #1;
        send_pair(16'h3C00, 16'h4000, t);
        wait_out(5, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("start_not_queued", {62'h0, busy, in_ready}, 64'h0);
        end
        @(posedge clock);
        #1;

        // Reset in WAIT aborts without a result
        do_start(8'd2, 32'h40400000);
        send_pair(16'h4000, 16'h4000, t);
        @(posedge clock);
        #2;
        resetn = 1'b0;
        #1;
        check_zero("abort");
        @(negedge clock);
        resetn = 1'b1;
        @(posedge clock);
        #1;
        exp_q.push_back(32'h3F800000);
        do_start(8'd1, 32'h00000000);
        send_pair(16'h3C00, 16'h3C00, t);
        wait_out(1, 1'b0);

        // NaN passes straight through from the MAC
        exp_q.push_back(fmac(16'h7E00, 16'h3C00, 32'h00000000));
        do_start(8'd1, 32'h00000000);
        send_pair(16'h7E00, 16'h3C00, t);
        wait_out(0, 1'b0);

        // Randomized dot products
        for (int r = 0; r < 25; r++) begin
            run_dot($urandom_range(0, 6),
                    {1'($urandom), 8'($urandom_range(120, 134)), 23'($urandom)},
                    3, $urandom_range(0, 3));
        end

        check("scoreboard_drained", 64'(exp_q.size()), 64'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
